bsub32_serial: RTL
==================

Name: bsub32_serial

Overview:
- Multi-cycle 32-bit subtractor with borrow-in; computes diff = R - T - Bin.
- Walks the operands one SLICE-bit slice per clock, LSB slice first, and chains the borrow through a register.
- It is the subtract-direction counterpart of the team's 8-bit-slice 32-bit adder chain, and uses the same R/T operand naming.
- Sits between an operand producer and a result consumer, with a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand and result width. Must be an integer multiple of SLICE; elaboration-time error otherwise.
- SLICE, 8, bits processed per RUN cycle. NSLICE = WIDTH/SLICE (4 at defaults).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- R  input  WIDTH  minuend.
- T  input  WIDTH  subtrahend.
- Bin  input  1  borrow-in.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- diff  output  WIDTH  R - T - Bin, modulo 2^WIDTH.
- Bout  output  1  borrow-out; 1 iff unsigned R < T + Bin.
- OF  output  1  two's-complement overflow of the subtraction.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.

Behaviour:
- Clock and reset: one clock (clk); rst_n is asynchronous, active-low.
- Reset: takes effect immediately, including mid-operation; no partial result survives.
  - state=IDLE, slice counter=0, borrow reg=0, operand regs=0.
  - diff=0, Bout=0, OF=0, out_valid=0.
  - in_ready=1, since it is decoded from IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a clock edge with in_valid=1: latch R, T; borrow reg=Bin; counter=0; go to RUN.
  - in_valid=0: stay in IDLE.
- RUN (one slice per cycle):
  - in_ready=0, out_valid=0.
  - Each edge computes {b, d} = R[slice k] - T[slice k] - borrow over SLICE+1 bits, with k = counter.
  - Write d into diff[slice k], borrow reg=b, counter+1.
  - On the edge processing k=NSLICE-1:
    - Bout = final borrow.
    - OF = (R[MSB]!=T[MSB]) && (d[SLICE-1]!=R[MSB]), using the latched R, T.
    - Go to DONE.
  - RUN lasts exactly NSLICE cycles.
- DONE:
  - out_valid=1, in_ready=0.
  - diff, Bout and OF are stable and held while out_ready=0.
  - On an edge with out_ready=1, go to IDLE.
- Handshake and latency:
  - An input transfer is in_valid & in_ready at an edge; an output transfer is out_valid & out_ready at an edge.
  - out_valid rises NSLICE cycles after the accept edge.
  - in_ready stays low from the accept edge until after the output transfer, so no new operand is accepted in the same cycle as the output transfer.
  - Minimum issue interval is NSLICE+2 cycles (6 at defaults).
- Input sampling:
  - R, T and Bin are sampled only at the accept edge.
  - Input changes during RUN or DONE have no effect.
  - in_valid asserted outside IDLE is ignored; it is not queued.
- Output validity:
  - diff, Bout and OF are meaningful only while out_valid=1.
  - Between operations they are not cleared; they hold their last value, with slices overwritten during RUN.
- Wrap-around: arithmetic is modulo 2^WIDTH.
  - 0 - 1 gives all-ones with Bout=1.
  - A borrow into slice 0 (Bin=1) propagates through every slice.

Optional Feature:
- Macro: BSUB32_SERIAL_ZERO_FLAG_EN
- When defined:
  - Adds output port ZF (1 bit).
  - ZF is registered and set on the last RUN edge to 1 iff the full WIDTH-bit diff is zero.
  - ZF is held in DONE and reset to 0.
- When undefined:
  - No ZF port and no zero-detect logic.
  - All other behaviour is identical.

Test Plan:
- R=0x00000005, T=0x00000003, Bin=0, accepted at edge k -> out_valid at edge k+4; diff=0x00000002, Bout=0, OF=0.
- R=0x00000000, T=0x00000001, Bin=0 -> diff=0xFFFFFFFF, Bout=1, OF=0.
- R=0x80000000, T=0x00000001, Bin=0 -> diff=0x7FFFFFFF, Bout=0, OF=1. Also R=0x7FFFFFFF, T=0xFFFFFFFF -> diff=0x80000000, Bout=1, OF=1.
- R=0x00000100, T=0x000000FF, Bin=1 (borrow crosses the slice 0/1 boundary) -> diff=0x00000000, Bout=0, OF=0; ZF=1 when BSUB32_SERIAL_ZERO_FLAG_EN is defined.
- Result pending with out_ready held 0 for 10 cycles, while in_valid=1 with new operands -> diff/Bout/OF unchanged, in_ready=0, new operands not taken. Set out_ready=1 -> IDLE next edge, new operands accepted on the following edge.
- rst_n pulsed low during the 2nd RUN cycle -> out_valid=0, diff=0, Bout=0, OF=0 immediately (asynchronous). After release: in_ready=1, and a fresh op (R=10, T=4) yields diff=6.

Source files
------------

// File: rtl/bsub32_serial.sv
// Multi-cycle subtractor: diff = R - T - Bin, one SLICE-bit slice per clock, LSB slice first.
// Optional zero flag output ZF is enabled by defining BSUB32_SERIAL_ZERO_FLAG_EN.
module bsub32_serial #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] R,
    input  logic [WIDTH-1:0] T,
    input  logic             Bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] diff,
    output logic             Bout,
    output logic             OF,
    output logic             out_valid,
    input  logic             out_ready
`ifdef BSUB32_SERIAL_ZERO_FLAG_EN
    ,
    output logic             ZF
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_width
        $error("bsub32_serial: WIDTH must be an integer multiple of SLICE");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, t_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;

    logic [SLICE-1:0] r_s, t_s;
    logic [SLICE:0]   sub;
    logic [WIDTH-1:0] diff_next;
    logic             accept, last;
    int               idx;

    // Slice datapath: the borrow is the sign bit of the (SLICE+1)-bit difference.
    always_comb begin
        idx       = int'(cnt_q) * SLICE;
        r_s       = r_q[idx +: SLICE];
        t_s       = t_q[idx +: SLICE];
        sub       = {1'b0, r_s} - {1'b0, t_s} - {{SLICE{1'b0}}, borrow_q};
        diff_next = diff;
        diff_next[idx +: SLICE] = sub[SLICE-1:0];
        accept    = (state_q == IDLE) && in_valid;
        last      = (state_q == RUN) && (cnt_q == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q      <= '0;
            t_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff     <= '0;
            Bout     <= 1'b0;
            OF       <= 1'b0;
        end else if (accept) begin
            r_q      <= R;
            t_q      <= T;
            borrow_q <= Bin;
            cnt_q    <= '0;
        end else if (state_q == RUN) begin
            diff     <= diff_next;
            borrow_q <= sub[SLICE];
            if (last) begin
                cnt_q <= '0;
                Bout  <= sub[SLICE];
                OF    <= (r_q[WIDTH-1] != t_q[WIDTH-1]) && (sub[SLICE-1] != r_q[WIDTH-1]);
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef BSUB32_SERIAL_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ZF <= 1'b0;
        else if (last) ZF <= (diff_next == '0);
    end
`endif

endmodule
